// File: rtl/param_seq_comparator.sv
// param_seq_comparator
// Multi-cycle magnitude comparator: scans two WIDTH-bit operands most
// significant digit first, DIGIT bits per clock, and reports L/E/G plus the
// number of digits examined. Two's-complement operands are handled by
// flipping the sign bit at capture so the scan itself is always unsigned.
// Optional feature macro: SEQ_CMP_EARLY_EXIT_EN -- when defined, the scan
// stops at the first differing digit; otherwise every scan runs all N digits.
module param_seq_comparator #(
   parameter int WIDTH = 32,
   parameter int DIGIT = 1
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 start,
   input  logic                                 signed_mode,
   input  logic [WIDTH-1:0]                     temp_a,
   input  logic [WIDTH-1:0]                     temp_b,
   output logic                                 busy,
   output logic                                 done,
   output logic                                 L,
   output logic                                 E,
   output logic                                 G,
   output logic [$clog2(WIDTH/DIGIT+1)-1:0]     digits
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = $clog2(N + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [CW-1:0] LAST_DIGIT = CW'(N - 1);

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             diff_q, diff_d;
   logic             diff_lt_q, diff_lt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             l_q, l_d;
   logic             e_q, e_d;
   logic             g_q, g_d;
   logic [CW-1:0]    digits_q, digits_d;

   logic [DIGIT-1:0] dig_a_s;
   logic [DIGIT-1:0] dig_b_s;
   logic             differ_s;
   logic             found_s;
   logic             lt_s;

   // Current top digit of the shifting operands and the running difference verdict
   always_comb begin
      dig_a_s  = a_q[WIDTH-1 -: DIGIT];
      dig_b_s  = b_q[WIDTH-1 -: DIGIT];
      differ_s = (dig_a_s != dig_b_s);
      found_s  = diff_q | differ_s;
      if (diff_q) begin
         lt_s = diff_lt_q;
      end else begin
         lt_s = (dig_a_s < dig_b_s);
      end
   end

   // Next-state logic for the IDLE/RUN/DONE sequencer and result registers
   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      diff_d    = diff_q;
      diff_lt_d = diff_lt_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      l_d       = l_q;
      e_d       = e_q;
      g_d       = g_q;
      digits_d  = digits_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               // Sign-bit flip maps two's-complement order onto unsigned order
               a_d       = {temp_a[WIDTH-1] ^ signed_mode, temp_a[WIDTH-2:0]};
               b_d       = {temp_b[WIDTH-1] ^ signed_mode, temp_b[WIDTH-2:0]};
               diff_d    = 1'b0;
               diff_lt_d = 1'b0;
               busy_d    = 1'b1;
               l_d       = 1'b0;
               e_d       = 1'b0;
               g_d       = 1'b0;
               digits_d  = {CW{1'b0}};
               state_d   = S_RUN;
            end else begin
               state_d = state_q;
            end
         end
         S_RUN: begin
            // Shift the next digit into the top position for the following cycle
            a_d       = a_q << DIGIT;
            b_d       = b_q << DIGIT;
            digits_d  = digits_q + CW'(1);
            diff_d    = found_s;
            diff_lt_d = lt_s;
`ifdef SEQ_CMP_EARLY_EXIT_EN
            if (differ_s || (digits_q == LAST_DIGIT)) begin
`else
            if (digits_q == LAST_DIGIT) begin
`endif
               state_d = S_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               l_d     = found_s & lt_s;
               g_d     = found_s & ~lt_s;
               e_d     = ~found_s;
            end else begin
               state_d = S_RUN;
            end
         end
         default: begin
            state_d  = S_IDLE;
            busy_d   = 1'b0;
            l_d      = 1'b0;
            e_d      = 1'b0;
            g_d      = 1'b0;
            digits_d = {CW{1'b0}};
         end
      endcase
   end

   // State and result registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         a_q       <= {WIDTH{1'b0}};
         b_q       <= {WIDTH{1'b0}};
         diff_q    <= 1'b0;
         diff_lt_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         l_q       <= 1'b0;
         e_q       <= 1'b0;
         g_q       <= 1'b0;
         digits_q  <= {CW{1'b0}};
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         diff_q    <= diff_d;
         diff_lt_q <= diff_lt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         l_q       <= l_d;
         e_q       <= e_d;
         g_q       <= g_d;
         digits_q  <= digits_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign L      = l_q;
   assign E      = e_q;
   assign G      = g_q;
   assign digits = digits_q;

endmodule

// File: tb/tb_param_seq_comparator.sv
// Scoreboard bench for param_seq_comparator: two instances (DIGIT=1 and
// DIGIT=4, WIDTH=32). Stimulus pushes expected results; monitors pop and
// compare on every done pulse. Honours SEQ_CMP_EARLY_EXIT_EN if defined.
module tb_param_seq_comparator;

`ifdef SEQ_CMP_EARLY_EXIT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   typedef struct {
      logic [2:0] leg;   // {L,E,G}
      int         dig;
      int         cyc;
   } exp_t;

   logic        clk;
   logic        reset;
   int          cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;

   logic        start1, sm1, busy1, done1, l1, e1, g1;
   logic [31:0] a1, b1;
   logic [5:0]  dig1;
   logic        start4, sm4, busy4, done4, l4, e4, g4;
   logic [31:0] a4, b4;
   logic [3:0]  dig4;

   exp_t q1[$];
   exp_t q4[$];
   exp_t m1;
   exp_t m4;

   param_seq_comparator #(.WIDTH(32), .DIGIT(1)) u_dut1 (
      .clk(clk), .reset(reset), .start(start1), .signed_mode(sm1),
      .temp_a(a1), .temp_b(b1), .busy(busy1), .done(done1),
      .L(l1), .E(e1), .G(g1), .digits(dig1)
   );

   param_seq_comparator #(.WIDTH(32), .DIGIT(4)) u_dut4 (
      .clk(clk), .reset(reset), .start(start4), .signed_mode(sm4),
      .temp_a(a4), .temp_b(b4), .busy(busy4), .done(done4),
      .L(l4), .E(e4), .G(g4), .digits(dig4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Called just after a negedge; capture happens at the next posedge
   task automatic issue1(input logic [31:0] a, input logic [31:0] b, input logic sm,
                         input logic [2:0] leg, input int early_dig, input bit expect_it);
      exp_t e;
      a1 = a; b1 = b; sm1 = sm; start1 = 1'b1;
      e.leg = leg;
      e.dig = EARLY ? early_dig : 32;
      e.cyc = cyc + 1 + e.dig;
      if (expect_it) q1.push_back(e);
   endtask

   task automatic issue4(input logic [31:0] a, input logic [31:0] b, input logic sm,
                         input logic [2:0] leg, input int early_dig);
      exp_t e;
      a4 = a; b4 = b; sm4 = sm; start4 = 1'b1;
      e.leg = leg;
      e.dig = EARLY ? early_dig : 8;
      e.cyc = cyc + 1 + e.dig;
      q4.push_back(e);
   endtask

   task automatic wait_done(input int which);
      int k = 0;
      while (((which == 1) ? done1 : done4) == 1'b0 && k < 100) begin
         @(negedge clk);
         k++;
      end
      check((which == 1) ? "done_timeout1" : "done_timeout4",
            int'((which == 1) ? done1 : done4), 1);
   endtask

   // Monitor for the DIGIT=1 instance
   always @(negedge clk) begin
      if (busy1) check("leg_zero_while_busy1", int'({l1, e1, g1}), 0);
      if (done1) begin
         if (q1.size() == 0) begin
            check("unexpected_done1", 1, 0);
         end else begin
            m1 = q1.pop_front();
            check("L1", int'(l1), int'(m1.leg[2]));
            check("E1", int'(e1), int'(m1.leg[1]));
            check("G1", int'(g1), int'(m1.leg[0]));
            check("digits1", int'(dig1), m1.dig);
            check("done_cycle1", cyc, m1.cyc);
            check("busy_at_done1", int'(busy1), 0);
         end
      end
   end

   // Monitor for the DIGIT=4 instance
   always @(negedge clk) begin
      if (done4) begin
         if (q4.size() == 0) begin
            check("unexpected_done4", 1, 0);
         end else begin
            m4 = q4.pop_front();
            check("L4", int'(l4), int'(m4.leg[2]));
            check("E4", int'(e4), int'(m4.leg[1]));
            check("G4", int'(g4), int'(m4.leg[0]));
            check("digits4", int'(dig4), m4.dig);
            check("done_cycle4", cyc, m4.cyc);
         end
      end
   end

   initial begin
      int k;
      logic [31:0] pa [3];
      logic [31:0] pb [3];
      logic [2:0]  pleg [3];
      int          pdig [3];
      pa[0] = 32'd10;   pb[0] = 32'd20;   pleg[0] = 3'b100; pdig[0] = 28;
      pa[1] = 32'd20;   pb[1] = 32'd10;   pleg[1] = 3'b001; pdig[1] = 28;
      pa[2] = 32'h55;   pb[2] = 32'h55;   pleg[2] = 3'b010; pdig[2] = 32;

      reset = 1'b0;
      start1 = 1'b0; sm1 = 1'b0; a1 = 32'd0; b1 = 32'd0;
      start4 = 1'b0; sm4 = 1'b0; a4 = 32'd0; b4 = 32'd0;
      repeat (3) @(negedge clk);
      check("rst_busy1", int'(busy1), 0);
      check("rst_done1", int'(done1), 0);
      check("rst_leg1", int'({l1, e1, g1}), 0);
      check("rst_digits1", int'(dig1), 0);
      check("rst_busy4", int'(busy4), 0);
      check("rst_leg4", int'({l4, e4, g4}), 0);
      reset = 1'b1;
      @(negedge clk);

      // Equal unsigned operands: full scan in every configuration
      issue1(32'd50, 32'd50, 1'b0, 3'b010, 32, 1'b1);
      @(negedge clk);
      start1 = 1'b0;
      check("busy_after_start1", int'(busy1), 1);
      check("done_low_running1", int'(done1), 0);
      wait_done(1);
      @(negedge clk);
      check("done_one_cycle1", int'(done1), 0);
      check("E_hold1", int'(e1), 1);
      check("digits_hold1", int'(dig1), 32);

      // Sign bit handling and signed ordering
      issue1(32'h8000_0000, 32'd1, 1'b0, 3'b001, 1, 1'b1);
      @(negedge clk); start1 = 1'b0; wait_done(1); @(negedge clk);
      issue1(32'h8000_0000, 32'd1, 1'b1, 3'b100, 1, 1'b1);
      @(negedge clk); start1 = 1'b0; wait_done(1); @(negedge clk);
      issue1(32'hFFFF_FFFF, 32'd0, 1'b1, 3'b100, 1, 1'b1);
      @(negedge clk); start1 = 1'b0; wait_done(1); @(negedge clk);
      issue1(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 3'b100, 1, 1'b1);
      @(negedge clk); start1 = 1'b0; wait_done(1); @(negedge clk);

      // Start during RUN is ignored: 5 < 9 differs first at bit 3 (digit 28)
      issue1(32'd5, 32'd9, 1'b0, 3'b100, 29, 1'b1);
      @(negedge clk); start1 = 1'b0;
      repeat (2) @(negedge clk);
      a1 = 32'd9; b1 = 32'd5; start1 = 1'b1;
      @(negedge clk); start1 = 1'b0;
      wait_done(1); @(negedge clk);

      // Reset in RUN cycle 10 discards the scan with no done pulse
      issue1(32'd3, 32'd3, 1'b0, 3'b010, 32, 1'b0);
      @(negedge clk); start1 = 1'b0;
      repeat (9) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("midrun_rst_busy1", int'(busy1), 0);
      check("midrun_rst_done1", int'(done1), 0);
      check("midrun_rst_leg1", int'({l1, e1, g1}), 0);
      check("midrun_rst_digits1", int'(dig1), 0);
      reset = 1'b1;
      repeat (40) @(negedge clk);
      issue1(32'd7, 32'd6, 1'b0, 3'b001, 32, 1'b1);
      @(negedge clk); start1 = 1'b0; wait_done(1); @(negedge clk);

      // start held high: each done cycle captures the next pair with no bubble
      issue1(pa[0], pb[0], 1'b0, pleg[0], pdig[0], 1'b1);
      for (int p = 1; p < 3; p++) begin
         @(negedge clk);
         wait_done(1);
         issue1(pa[p], pb[p], 1'b0, pleg[p], pdig[p], 1'b1);
         @(negedge clk);
         check("b2b_busy1", int'(busy1), 1);
         check("b2b_done_low1", int'(done1), 0);
      end
      @(negedge clk);
      wait_done(1);
      start1 = 1'b0;
      @(negedge clk);
      check("b2b_idle_busy1", int'(busy1), 0);

      // DIGIT=4 instance: difference only in the last nibble, then signed case
      issue4(32'h1234_5678, 32'h1234_5679, 1'b0, 3'b100, 8);
      @(negedge clk); start4 = 1'b0;
      check("busy_after_start4", int'(busy4), 1);
      wait_done(4); @(negedge clk);
      issue4(32'h8000_0000, 32'd1, 1'b1, 3'b100, 1);
      @(negedge clk); start4 = 1'b0; wait_done(4); @(negedge clk);

      k = 0;
      while ((q1.size() != 0 || q4.size() != 0) && k < 200) begin
         @(negedge clk);
         k++;
      end
      check("queue_empty1", q1.size(), 0);
      check("queue_empty4", q4.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/param_seq_comparator.md
# param_seq_comparator

Parametrised multi-cycle magnitude comparator, successor to the fixed 32-bit bit-serial comparator. It scans two WIDTH-bit operands most-significant digit first, DIGIT bits per clock. It supports unsigned and two's-complement modes, a start/busy/done handshake and optional early termination. It sits in the datapath test area as a drop-in sequential L/E/G source for wider or signed operands.

## Interface
- WIDTH, 32: operand width in bits; must be ≥ 2.
- DIGIT, 1: bits compared per cycle; must divide WIDTH. N = WIDTH/DIGIT digits.
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset; one clock, sampled on the rising edge of clk.
- start  in  1  request a comparison; sampled only when not busy.
- signed_mode  in  1  1 = two's-complement, 0 = unsigned; captured with the operands.
- temp_a  in  WIDTH  operand A; captured on the accepted start.
- temp_b  in  WIDTH  operand B; captured on the accepted start.
- busy  out  1  comparison in progress.
- done  out  1  one-cycle pulse when the result becomes valid.
- L  out  1  A < B.
- E  out  1  A == B.
- G  out  1  A > B.
- digits  out  $clog2(N+1)  number of digits examined for the last result.

## Operation
- States: IDLE, RUN, DONE.
- Reset (reset=0 at a clock edge):
  - state=IDLE; busy=0, done=0, L=E=G=0, digits=0.
  - Internal operand registers and digit index are cleared.
  - Reset wins over a simultaneous start.
- Acceptance:
  - start=1 in IDLE or DONE at edge n captures temp_a, temp_b and signed_mode.
  - State goes to RUN, busy=1, L=E=G=0, digit index=0, digits=0.
- Signed handling:
  - At capture, bit WIDTH-1 of both operands is inverted when signed_mode=1.
  - The RUN comparison is then always unsigned.
  - Result: −1 < 0, and 0x8000_0000 < 0x7FFF_FFFF for WIDTH=32.
- RUN, each cycle:
  - Compare digit j, i.e. bits [WIDTH-1-j*DIGIT -: DIGIT], of both captured operands; digits increments.
  - If the digits differ and early exit is enabled: set L or G, go to DONE.
  - Without early exit, the first difference is latched internally and scanning continues.
  - After digit N-1: set the latched L/G, or E=1 if no difference was found; go to DONE.
- DONE:
  - done=1 for exactly the entry cycle; busy=0.
  - L/E/G and digits hold until the next accepted start or reset.
  - The FSM stays in DONE (done=0 after the first cycle) until start.
- start while busy is ignored; the operands and mode in flight are unaffected.
- L, E, G are one-hot whenever a result is valid, and all zero while busy.

## Timing
- Capture at edge n; digit j is evaluated at edge n+1+j.
- Full-scan latency: done and result are visible after edge n+N. For WIDTH=32, DIGIT=1: 32 cycles; DIGIT=4: 8 cycles.
- Early-exit latency: first difference at digit j gives done after edge n+j+1; digits=j+1.
- Back-to-back: start=1 in the done cycle is accepted at that edge. done drops, L/E/G clear and busy rises on the next cycle; no idle bubble.
- Reset mid-RUN: IDLE at that edge; no done pulse; the partial result is discarded.
- No combinational path from inputs to outputs; all outputs are registered.

## Configuration
- SEQ_CMP_EARLY_EXIT_EN defined: RUN terminates on the first differing digit, so latency varies from 1 to N.
- SEQ_CMP_EARLY_EXIT_EN undefined:
  - Every comparison takes exactly N RUN cycles and digits always reads N on completion.
  - L/E/G values are identical to the defined case; only timing differs.

## Test plan
- WIDTH=32, DIGIT=1, unsigned, A=B=50 -> E=1, L=G=0, done pulse 32 cycles after start, digits=32.
- WIDTH=32, DIGIT=1, A=0x8000_0000, B=1:
  - unsigned -> G=1.
  - signed -> L=1.
  - With SEQ_CMP_EARLY_EXIT_EN: done 1 cycle after capture, digits=1. Without: 32 cycles.
- WIDTH=32, DIGIT=4, A=0x1234_5678, B=0x1234_5679 -> L=1 after 8 cycles, digits=8 (both configurations).
- Start A=5, B=9; pulse start with A=9, B=5 at cycle 3 of RUN -> second start ignored; final L=1 for the first pair.
- Assert reset=0 at RUN cycle 10 -> next edge: busy=0, done never pulses, L=E=G=0. A new start afterwards completes normally.
- Hold start=1 continuously with alternating operand pairs -> each done pulse is followed by an immediate new capture, and every result is correct.
